cpu_control_unit: RTL and testbench

- Instruction decoder and step sequencer for the bus-based CPU. It is the consumer side of the component set: it drives the multiplexer `sel` encoding, `register_n` enables and the ALU `alu_op`.
- It latches a 9-bit instruction from Din, then steps T0..T3 to issue one bus transfer per cycle. It raises `done` on the final step.
- It replaces `tick_FSM` in the datapath top level by keeping its own step counter.

---
 rtl/cpu_control_unit.sv | 140 ++++++++++++++
 tb/tb_cpu_control_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : cpu_control_unit
// Description : Instruction decoder and T0..T3 step sequencer for the
//               bus-based CPU. Latches a 9-bit instruction, then issues one
//               bus transfer per step, driving the bus mux select, register
//               write enables and ALU opcode. Moore outputs only.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit #(
    parameter int unsigned IW      = 9,
    parameter logic [3:0]  SEL_G   = 4'd8,
    parameter logic [3:0]  SEL_DIN = 4'd9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [IW-1:0] din,
    output logic [3:0]    bus_sel,
    output logic [7:0]    r_in,
    output logic          a_in,
    output logic          g_in,
    output logic [2:0]    alu_op,
    output logic          done,
    output logic          busy,
    output logic [IW-1:0] ir
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_NOP = 3'b111;

    step_t         step_q, step_d;
    logic [IW-1:0] ir_q, ir_d;

    logic [2:0]    w_opcode;
    logic [2:0]    w_rx;
    logic [2:0]    w_ry;
    logic          w_is_alu;
    logic [2:0]    w_alu_map;
    logic [7:0]    w_rx_onehot;

    // Field extraction and static decodes of the latched instruction
    always_comb begin
        w_opcode    = ir_q[8:6];
        w_rx        = ir_q[5:3];
        w_ry        = ir_q[2:0];
        w_is_alu    = (w_opcode != OP_MV) && (w_opcode != OP_MVI) && (w_opcode != OP_NOP);
        w_alu_map   = w_is_alu ? (w_opcode - 3'd2) : 3'b000;
        w_rx_onehot = 8'b0000_0001 << w_rx;
    end

    // Step and instruction registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Next-step logic and per-step bus transfer decode
    always_comb begin
        step_d  = step_q;
        ir_d    = ir_q;
        bus_sel = 4'd0;
        r_in    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = 3'b000;
        done    = 1'b0;

        case (step_q)
            T0: begin
                // run is only honoured here, so requests while busy are dropped
                if (run) begin
                    ir_d   = din;
                    step_d = T1;
                end
            end
            T1: begin
                case (w_opcode)
                    OP_MV: begin
                        bus_sel = {1'b0, w_ry};
                        r_in    = w_rx_onehot;
                        done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_MVI: begin
                        bus_sel = SEL_DIN;
                        r_in    = w_rx_onehot;
                        done    = 1'b1;
                        step_d  = T0;
                    end
                    OP_NOP: begin
                        done   = 1'b1;
                        step_d = T0;
                    end
                    default: begin
                        // ALU ops: load operand A from Rx first
                        bus_sel = {1'b0, w_rx};
                        a_in    = 1'b1;
                        step_d  = T2;
                    end
                endcase
            end
            T2: begin
                // Only ALU ops reach T2: operand B from Ry, result into G
                bus_sel = {1'b0, w_ry};
                alu_op  = w_alu_map;
                g_in    = 1'b1;
                step_d  = T3;
            end
            T3: begin
                // Write G back into the destination register
                bus_sel = SEL_G;
                r_in    = w_rx_onehot;
                done    = 1'b1;
                step_d  = T0;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

    assign busy = (step_q != T0);
    assign ir   = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Directed self-checking bench for cpu_control_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_control_unit;

    logic       clk;
    logic       rst;
    logic       run;
    logic [8:0] din;
    logic [3:0] bus_sel;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic [2:0] alu_op;
    logic       done;
    logic       busy;
    logic [8:0] ir;

    int total;
    int bad;

    cpu_control_unit #(
        .IW      (9),
        .SEL_G   (4'd8),
        .SEL_DIN (4'd9)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .bus_sel (bus_sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .alu_op  (alu_op),
        .done    (done),
        .busy    (busy),
        .ir      (ir)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".bus_sel"}, 32'(bus_sel), 32'd0);
        chk({tag, ".r_in"},    32'(r_in),    32'd0);
        chk({tag, ".a_in"},    32'(a_in),    32'd0);
        chk({tag, ".g_in"},    32'(g_in),    32'd0);
        chk({tag, ".alu_op"},  32'(alu_op),  32'd0);
        chk({tag, ".done"},    32'(done),    32'd0);
        chk({tag, ".busy"},    32'(busy),    32'd0);
    endtask

    // Full three-step ALU instruction with expected mapped opcode
    task automatic do_alu(input string tag, input logic [2:0] op, input logic [2:0] rx,
                          input logic [2:0] ry, input logic [2:0] exp_alu);
        logic [7:0] onehot;
        onehot = 8'b0000_0001 << rx;
        din = {op, rx, ry};
        run = 1'b1;
        tick();
        run = 1'b0;
        chk({tag, ".t1.bus_sel"}, 32'(bus_sel), 32'(rx));
        chk({tag, ".t1.a_in"},    32'(a_in),    32'd1);
        chk({tag, ".t1.g_in"},    32'(g_in),    32'd0);
        chk({tag, ".t1.r_in"},    32'(r_in),    32'd0);
        chk({tag, ".t1.done"},    32'(done),    32'd0);
        chk({tag, ".t1.busy"},    32'(busy),    32'd1);
        tick();
        chk({tag, ".t2.bus_sel"}, 32'(bus_sel), 32'(ry));
        chk({tag, ".t2.alu_op"},  32'(alu_op),  32'(exp_alu));
        chk({tag, ".t2.g_in"},    32'(g_in),    32'd1);
        chk({tag, ".t2.a_in"},    32'(a_in),    32'd0);
        chk({tag, ".t2.r_in"},    32'(r_in),    32'd0);
        chk({tag, ".t2.done"},    32'(done),    32'd0);
        tick();
        chk({tag, ".t3.bus_sel"}, 32'(bus_sel), 32'd8);
        chk({tag, ".t3.r_in"},    32'(r_in),    32'(onehot));
        chk({tag, ".t3.done"},    32'(done),    32'd1);
        chk({tag, ".t3.alu_op"},  32'(alu_op),  32'd0);
        chk({tag, ".t3.g_in"},    32'(g_in),    32'd0);
        tick();
        chk({tag, ".end.busy"},   32'(busy),    32'd0);
        chk({tag, ".end.done"},   32'(done),    32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset held across two edges with run asserted
        rst = 1'b0;
        run = 1'b1;
        din = 9'o234;
        tick();
        chk_idle("rst1");
        chk("rst1.ir", 32'(ir), 32'd0);
        tick();
        chk_idle("rst2");
        chk("rst2.ir", 32'(ir), 32'd0);
        rst = 1'b1;
        run = 1'b0;
        tick();
        chk_idle("post_rst");
        tick();
        chk("post_rst2.busy", 32'(busy), 32'd0);

        // mv R5,R2
        din = 9'o052;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("mv.bus_sel", 32'(bus_sel), 32'd2);
        chk("mv.r_in",    32'(r_in),    32'h20);
        chk("mv.done",    32'(done),    32'd1);
        chk("mv.busy",    32'(busy),    32'd1);
        chk("mv.a_in",    32'(a_in),    32'd0);
        chk("mv.ir",      32'(ir),      32'(9'o052));
        tick();
        chk("mv.end.busy", 32'(busy), 32'd0);
        chk("mv.end.done", 32'(done), 32'd0);

        // mvi R3 with immediate presented during T1
        din = 9'o130;
        run = 1'b1;
        tick();
        run = 1'b0;
        din = 9'h1C5;
        chk("mvi.bus_sel", 32'(bus_sel), 32'd9);
        chk("mvi.r_in",    32'(r_in),    32'h08);
        chk("mvi.done",    32'(done),    32'd1);
        chk("mvi.ir",      32'(ir),      32'(9'o130));
        tick();
        chk("mvi.end.busy", 32'(busy), 32'd0);

        // ALU ops and opcode mapping
        do_alu("sub",  3'b011, 3'd1, 3'd4, 3'b001);
        do_alu("add",  3'b010, 3'd6, 3'd0, 3'b000);
        do_alu("mul",  3'b100, 3'd7, 3'd5, 3'b010);
        do_alu("shl",  3'b101, 3'd0, 3'd3, 3'b011);
        do_alu("shr",  3'b110, 3'd2, 3'd7, 3'b100);
        do_alu("addrr", 3'b010, 3'd3, 3'd3, 3'b000);

        // run during T2 of a mul is ignored
        din = 9'o426;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("ign.t2.g_in", 32'(g_in), 32'd1);
        run = 1'b1;
        din = 9'o007;
        tick();
        run = 1'b0;
        chk("ign.t3.ir",   32'(ir),   32'(9'o426));
        chk("ign.t3.done", 32'(done), 32'd1);
        chk("ign.t3.r_in", 32'(r_in), 32'h04);
        tick();
        chk("ign.end.busy", 32'(busy), 32'd0);
        chk("ign.end.ir",   32'(ir),   32'(9'o426));

        // Asynchronous reset in T2 of a second mul
        din = 9'o417;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        chk("abort.t2.g_in", 32'(g_in), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_idle("abort.async");
        chk("abort.async.ir", 32'(ir), 32'd0);
        tick();
        chk_idle("abort.held");
        rst = 1'b1;
        tick();
        chk_idle("abort.rel1");
        tick();
        chk_idle("abort.rel2");

        // nop with run held high: back-to-back recapture every other cycle
        din = 9'o777;
        run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nop.t1.done", 32'(done), 32'd1);
            chk("nop.t1.busy", 32'(busy), 32'd1);
            chk("nop.t1.en",   32'({r_in, a_in, g_in}), 32'd0);
            chk("nop.t1.bus_sel", 32'(bus_sel), 32'd0);
            tick();
            chk("nop.t0.done", 32'(done), 32'd0);
            chk("nop.t0.busy", 32'(busy), 32'd0);
            chk("nop.t0.en",   32'({r_in, a_in, g_in}), 32'd0);
        end
        run = 1'b0;
        tick();
        chk("nop.end.busy", 32'(busy), 32'd0);
        chk("nop.end.ir",   32'(ir),   32'(9'o777));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
